// File: rtl/arm_pkg.sv
// ARM decode constants, field positions, control bundle type
// and the condition / control decode helpers.
package arm_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_VS = 4'b0110;
  localparam logic [3:0] CC_VC = 4'b0111;
  localparam logic [3:0] CC_HI = 4'b1000;
  localparam logic [3:0] CC_LS = 4'b1001;
  localparam logic [3:0] CC_GE = 4'b1010;
  localparam logic [3:0] CC_LT = 4'b1011;
  localparam logic [3:0] CC_GT = 4'b1100;
  localparam logic [3:0] CC_LE = 4'b1101;
  localparam logic [3:0] CC_AL = 4'b1110;

  localparam int COND_LO = 28;
  localparam int MODE_LO = 26;
  localparam int I_BIT   = 25;
  localparam int OP_LO   = 21;
  localparam int S_BIT   = 20;
  localparam int RN_LO   = 16;
  localparam int RD_LO   = 12;
  localparam int RM_LO   = 0;

  typedef struct packed {
    logic [3:0] exec_cmd;
    logic       mem_r;
    logic       mem_w;
    logic       wb;
    logic       branch;
    logic       status_en;
  } ctrl_t;

  // nzcv = {N, Z, C, V}; code 1111 never passes
  function automatic logic cond_pass(
    input logic [3:0] cc,
    input logic [3:0] nzcv
  );
    logic n, z, c, v;
    logic r;
    {n, z, c, v} = nzcv;
    r = 1'b0;
    case (cc)
      CC_EQ:   r = z;
      CC_NE:   r = ~z;
      CC_CS:   r = c;
      CC_CC:   r = ~c;
      CC_MI:   r = n;
      CC_PL:   r = ~n;
      CC_VS:   r = v;
      CC_VC:   r = ~v;
      CC_HI:   r = c & ~z;
      CC_LS:   r = ~c | z;
      CC_GE:   r = (n == v);
      CC_LT:   r = (n != v);
      CC_GT:   r = ~z & (n == v);
      CC_LE:   r = z | (n != v);
      CC_AL:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic ctrl_t dp_decode(
    input logic [3:0] op,
    input logic       s
  );
    ctrl_t c;
    c = '0;
    c.wb = 1'b1;
    c.status_en = s;
    case (op)
      OP_MOV:  c.exec_cmd = EXE_MOV;
      OP_MVN:  c.exec_cmd = EXE_MVN;
      OP_ADD:  c.exec_cmd = EXE_ADD;
      OP_ADC:  c.exec_cmd = EXE_ADC;
      OP_SUB:  c.exec_cmd = EXE_SUB;
      OP_SBC:  c.exec_cmd = EXE_SBC;
      OP_AND:  c.exec_cmd = EXE_AND;
      OP_ORR:  c.exec_cmd = EXE_ORR;
      OP_EOR:  c.exec_cmd = EXE_EOR;
      OP_CMP: begin
        c.exec_cmd = EXE_SUB;
        c.wb = 1'b0;
      end
      OP_TST: begin
        c.exec_cmd = EXE_AND;
        c.wb = 1'b0;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctrl_t ctrl_decode(
    input logic [1:0] mode,
    input logic [3:0] op,
    input logic       s
  );
    ctrl_t c;
    c = '0;
    unique case (1'b1)
      (mode == MODE_DP): c = dp_decode(op, s);
      (mode == MODE_MEM): begin
        c.exec_cmd = EXE_ADD;
        c.mem_r = s;
        c.wb = s;
        c.mem_w = ~s;
      end
      (mode == MODE_BR): c.branch = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_reg_file.sv
// Register file: sync clear, bounded writes, two comb reads.
// RF_BYPASS_EN selects write-through forwarding on reads.
module id_reg_file #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 16,
  parameter int RF_ADDR_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [RF_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [RF_ADDR_W-1:0] raddr_a_i,
  input  logic [RF_ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0]    rdata_a_o,
  output logic [DATA_W-1:0]    rdata_b_o
);

  localparam logic [RF_ADDR_W:0] CNT =
    (RF_ADDR_W+1)'(REG_COUNT);

  logic [DATA_W-1:0] rf_q [REG_COUNT];

  function automatic logic in_rng(
    input logic [RF_ADDR_W-1:0] a
  );
    return {1'b0, a} < CNT;
  endfunction

  function automatic logic [DATA_W-1:0] rd(
    input logic [RF_ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (in_rng(a)) v = rf_q[a];
`ifdef RF_BYPASS_EN
    if (we_i && in_rng(waddr_i) && waddr_i == a)
      v = wdata_i;
`endif
    return v;
  endfunction

  // clear on reset, otherwise write in-range addresses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_COUNT; i++)
        rf_q[i] <= '0;
    end else if (we_i && in_rng(waddr_i)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  // combinational read ports
  always_comb begin
    rdata_a_o = rd(raddr_a_i);
    rdata_b_o = rd(raddr_b_i);
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// ARM decode stage with built-in ID/EX register.
// Optional macro RF_BYPASS_EN: register file write-through.
module id_stage_pipelined
  import arm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_COUNT = 16,
  parameter int RF_ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ADDR_W-1:0]    pc_in,
  input  logic [31:0]          instruction,
  input  logic [3:0]           status_reg,
  input  logic                 hazard,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [RF_ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]    wb_value,
  output logic [RF_ADDR_W-1:0] src_1,
  output logic [RF_ADDR_W-1:0] src_2,
  output logic                 two_src,
  output logic                 out_valid,
  output logic [3:0]           exec_cmd,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic                 wb_en_out,
  output logic                 branch_taken,
  output logic                 status_en,
  output logic [DATA_W-1:0]    val_rn,
  output logic [DATA_W-1:0]    val_rm,
  output logic                 imm,
  output logic [11:0]          shift_operand,
  output logic [23:0]          signed_imm_24,
  output logic [RF_ADDR_W-1:0] dest,
  output logic [ADDR_W-1:0]    pc_out
);

  logic [3:0] cond_w, op_w;
  logic [1:0] mode_w;
  logic       i_w, s_w, store_w, kill_w;
  logic [RF_ADDR_W-1:0] rn_w, rd_w, rm_w;
  logic [DATA_W-1:0] rn_val_w, rm_val_w;
  ctrl_t ctrl_d;

  assign cond_w = instruction[COND_LO +: 4];
  assign mode_w = instruction[MODE_LO +: 2];
  assign i_w    = instruction[I_BIT];
  assign op_w   = instruction[OP_LO +: 4];
  assign s_w    = instruction[S_BIT];
  assign rn_w   = RF_ADDR_W'(instruction[RN_LO +: 4]);
  assign rd_w   = RF_ADDR_W'(instruction[RD_LO +: 4]);
  assign rm_w   = RF_ADDR_W'(instruction[RM_LO +: 4]);

  assign store_w = (mode_w == MODE_MEM) & ~s_w;
  assign src_1   = rn_w;
  assign src_2   = store_w ? rd_w : rm_w;
  assign two_src = ~i_w | store_w;

  assign ctrl_d = ctrl_decode(mode_w, op_w, s_w);
  assign kill_w = ~in_valid | hazard
                | ~cond_pass(cond_w, status_reg);

  id_reg_file #(
    .DATA_W   (DATA_W),
    .REG_COUNT(REG_COUNT),
    .RF_ADDR_W(RF_ADDR_W)
  ) u_rf (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (wb_en),
    .waddr_i  (wb_dest),
    .wdata_i  (wb_value),
    .raddr_a_i(src_1),
    .raddr_b_i(src_2),
    .rdata_a_o(rn_val_w),
    .rdata_b_o(rm_val_w)
  );

  logic                 valid_q;
  ctrl_t                ctrl_q;
  logic [DATA_W-1:0]    rn_q, rm_q;
  logic                 imm_q;
  logic [11:0]          sh_q;
  logic [23:0]          simm_q;
  logic [RF_ADDR_W-1:0] dest_q;
  logic [ADDR_W-1:0]    pc_q;

  // ID/EX register: rst > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      imm_q   <= 1'b0;
      sh_q    <= '0;
      simm_q  <= '0;
      dest_q  <= '0;
      pc_q    <= '0;
    end else if (!stall) begin
      valid_q <= ~kill_w;
      ctrl_q  <= kill_w ? '0 : ctrl_d;
      rn_q    <= rn_val_w;
      rm_q    <= rm_val_w;
      imm_q   <= i_w;
      sh_q    <= instruction[11:0];
      simm_q  <= instruction[23:0];
      dest_q  <= rd_w;
      pc_q    <= pc_in;
    end
  end

  assign out_valid     = valid_q;
  assign exec_cmd      = ctrl_q.exec_cmd;
  assign mem_r_en      = ctrl_q.mem_r;
  assign mem_w_en      = ctrl_q.mem_w;
  assign wb_en_out     = ctrl_q.wb;
  assign branch_taken  = ctrl_q.branch;
  assign status_en     = ctrl_q.status_en;
  assign val_rn        = rn_q;
  assign val_rm        = rm_q;
  assign imm           = imm_q;
  assign shift_operand = sh_q;
  assign signed_imm_24 = simm_q;
  assign dest          = dest_q;
  assign pc_out        = pc_q;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined.
// Expected bundles are queued at drive time, popped after the edge.
module tb_id_stage_pipelined;

  typedef struct packed {
    logic        valid;
    logic [3:0]  exec;
    logic        mr, mw, wb, br, se;
    logic [31:0] rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 0;
  logic        rst, in_valid, hazard, stall, flush, wb_en;
  logic [31:0] pc_in, instruction, wb_value;
  logic [3:0]  status_reg, wb_dest;
  logic [3:0]  src_1, src_2, exec_cmd, dest;
  logic        two_src, out_valid, mem_r_en, mem_w_en;
  logic        wb_en_out, branch_taken, status_en, imm;
  logic [31:0] val_rn, val_rm, pc_out;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;

  int n_err = 0;
  int n_chk = 0;
  exp_t sbq[$];
  logic [31:0] rf_m [16];
  exp_t last_e;

  always #5 clk = ~clk;

  id_stage_pipelined dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .pc_in(pc_in), .instruction(instruction),
    .status_reg(status_reg), .hazard(hazard),
    .stall(stall), .flush(flush), .wb_en(wb_en),
    .wb_dest(wb_dest), .wb_value(wb_value),
    .src_1(src_1), .src_2(src_2), .two_src(two_src),
    .out_valid(out_valid), .exec_cmd(exec_cmd),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_en_out(wb_en_out), .branch_taken(branch_taken),
    .status_en(status_en), .val_rn(val_rn),
    .val_rm(val_rm), .imm(imm),
    .shift_operand(shift_operand),
    .signed_imm_24(signed_imm_24),
    .dest(dest), .pc_out(pc_out)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic is_store(input logic [31:0] ins);
    return ins[27:26] == 2'b01 && !ins[20];
  endfunction

  // expected bundle; ctl = {valid,exec,mr,mw,wb,br,se}
  function automatic exp_t model(input logic [31:0] ins,
                                 input logic [31:0] pc,
                                 input logic [9:0] ctl,
                                 input logic [31:0] rn);
    exp_t e;
    logic [3:0] a2;
    a2 = is_store(ins) ? ins[15:12] : ins[3:0];
    {e.valid, e.exec, e.mr, e.mw, e.wb, e.br, e.se} = ctl;
    e.rn   = rn;
    e.rm   = rf_m[a2];
    e.imm  = ins[25];
    e.sh   = ins[11:0];
    e.simm = ins[23:0];
    e.dest = ins[15:12];
    e.pc   = pc;
    return e;
  endfunction

  task automatic cmp_out(input string t);
    exp_t e;
    e = sbq.pop_front();
    chk({t, ".valid"}, 64'(out_valid), 64'(e.valid));
    chk({t, ".exec"}, 64'(exec_cmd), 64'(e.exec));
    chk({t, ".mr"}, 64'(mem_r_en), 64'(e.mr));
    chk({t, ".mw"}, 64'(mem_w_en), 64'(e.mw));
    chk({t, ".wb"}, 64'(wb_en_out), 64'(e.wb));
    chk({t, ".br"}, 64'(branch_taken), 64'(e.br));
    chk({t, ".se"}, 64'(status_en), 64'(e.se));
    chk({t, ".rn"}, 64'(val_rn), 64'(e.rn));
    chk({t, ".rm"}, 64'(val_rm), 64'(e.rm));
    chk({t, ".imm"}, 64'(imm), 64'(e.imm));
    chk({t, ".sh"}, 64'(shift_operand), 64'(e.sh));
    chk({t, ".simm"}, 64'(signed_imm_24), 64'(e.simm));
    chk({t, ".dest"}, 64'(dest), 64'(e.dest));
    chk({t, ".pc"}, 64'(pc_out), 64'(e.pc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive one instruction, queue its expectation, compare
  task automatic issue(input string t, input logic [31:0] ins,
                       input logic [3:0] nzcv,
                       input logic hz, input exp_t e);
    instruction = ins;
    status_reg  = nzcv;
    hazard      = hz;
    in_valid    = 1'b1;
    pc_in       = pc_in + 32'd4;
    #1;
    chk({t, ".src1"}, 64'(src_1), 64'(ins[19:16]));
    chk({t, ".src2"}, 64'(src_2),
        64'(is_store(ins) ? ins[15:12] : ins[3:0]));
    chk({t, ".two"}, 64'(two_src),
        64'(!ins[25] || is_store(ins)));
    sbq.push_back(e);
    step();
    cmp_out(t);
    last_e = e;
    hazard = 1'b0;
  endtask

  task automatic rf_write(input logic [3:0] a,
                          input logic [31:0] v);
    in_valid = 1'b0;
    wb_en    = 1'b1;
    wb_dest  = a;
    wb_value = v;
    step();
    rf_m[a] = v;
    wb_en = 1'b0;
  endtask

  typedef struct {
    string       t;
    logic [31:0] ins;
    logic [3:0]  nzcv;
    logic        hz;
    logic [9:0]  ctl;
  } vec_t;

  vec_t vt[$];
  logic [31:0] p;
  exp_t z;

  initial begin
    z = '0;
    for (int i = 0; i < 16; i++) rf_m[i] = '0;
    rst = 1; in_valid = 0; hazard = 0; stall = 0;
    flush = 0; wb_en = 0; wb_dest = 0; wb_value = 0;
    pc_in = 32'h100; instruction = 32'hE0813002;
    status_reg = 0;
    sbq.push_back(z);
    step(); step();
    cmp_out("reset");
    rst = 0;

    issue("rd_r3", 32'hE0834001, 4'h0, 1'b0,
          model(32'hE0834001, pc_in + 4,
                10'b1_0010_00100, rf_m[3]));
    rf_write(4'd1, 32'd5);
    rf_write(4'd2, 32'd7);

    vt = '{
      '{"add",   32'hE0813002, 4'h0, 1'b0, 10'b1_0010_00100},
      '{"eqfail",32'h00813002, 4'h0, 1'b0, 10'b0_0000_00000},
      '{"hazard",32'hE0813002, 4'h0, 1'b1, 10'b0_0000_00000},
      '{"eqpass",32'h00813002, 4'h4, 1'b0, 10'b1_0010_00100},
      '{"nv",    32'hF0813002, 4'hF, 1'b0, 10'b0_0000_00000},
      '{"ge",    32'hA0813002, 4'h9, 1'b0, 10'b1_0010_00100},
      '{"gtfail",32'hC0813002, 4'h4, 1'b0, 10'b0_0000_00000},
      '{"cmp",   32'hE1510002, 4'h0, 1'b0, 10'b1_0100_00001},
      '{"store", 32'hE5812000, 4'h0, 1'b0, 10'b1_0010_01000},
      '{"load",  32'hE5912000, 4'h0, 1'b0, 10'b1_0010_10100},
      '{"branch",32'hEA000010, 4'h0, 1'b0, 10'b1_0000_00010},
      '{"undef", 32'hEC000000, 4'h0, 1'b0, 10'b1_0000_00000},
      '{"movi",  32'hE3A05007, 4'h0, 1'b0, 10'b1_0001_00100}
    };
    foreach (vt[i]) begin
      p = pc_in + 4;
      issue(vt[i].t, vt[i].ins, vt[i].nzcv, vt[i].hz,
            model(vt[i].ins, p, vt[i].ctl,
                  rf_m[vt[i].ins[19:16]]));
    end

    stall = 1'b1;
    for (int k = 0; k < 3; k++)
      issue("stall", 32'hE0813002, 4'h0, 1'b0, last_e);
    flush = 1'b1;
    issue("stflush", 32'hE0813002, 4'h0, 1'b0, z);
    stall = 1'b0;
    issue("flush", 32'hE5912000, 4'h0, 1'b0, z);
    flush = 1'b0;

    wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'd99;
    p = pc_in + 4;
`ifdef RF_BYPASS_EN
    issue("bypass", 32'hE0813002, 4'h0, 1'b0,
          model(32'hE0813002, p, 10'b1_0010_00100, 32'd99));
`else
    issue("bypass", 32'hE0813002, 4'h0, 1'b0,
          model(32'hE0813002, p, 10'b1_0010_00100, 32'd5));
`endif
    wb_en = 1'b0;
    rf_m[1] = 32'd99;
    p = pc_in + 4;
    issue("after_wb", 32'hE0813002, 4'h0, 1'b0,
          model(32'hE0813002, p, 10'b1_0010_00100, rf_m[1]));

    rst = 1'b1; wb_en = 1'b1; wb_dest = 4'd2;
    wb_value = 32'd3;
    issue("midrst", 32'hE0813002, 4'h0, 1'b0, z);
    rst = 1'b0; wb_en = 1'b0;
    for (int i = 0; i < 16; i++) rf_m[i] = '0;
    pc_in = 32'h200;
    issue("postrst", 32'hE0813002, 4'h0, 1'b0,
          model(32'hE0813002, 32'h204,
                10'b1_0010_00100, 32'd0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
